spi_master: RTL
===============

Name: spi_master

Overview:
- Single-byte SPI mode-0 controller, MSB first. Drives sck, ss and mosi to an external SPI slave and captures miso.
- Host side is a start/busy/done handshake. Each start transfers one byte in each direction.
- Sits between on-chip logic and the off-chip `spi` slave peripheral, which samples mosi on rising sck and shifts miso on falling sck.

Parameters:
- CLK_DIV, 25, clk cycles per sck half-period. Legal range is 2 or more; 25 at 50 MHz gives a 500 ns half-period.

Ports:
- clk  input  1  system clock; everything updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  begin a transfer; sampled only when busy=0.
- tx_data  input  8  byte to send; captured on the clk edge that accepts start.
- ss_hold  input  1  captured with start. 1 keeps ss low after the byte completes.
- rx_data  output  8  last received byte; updated only in the cycle done=1.
- busy  output  1  transfer or ss-gap in progress.
- done  output  1  one-cycle pulse when a byte completes.
- sck  output  1  SPI clock; idles low.
- ss  output  1  slave select, active low.
- mosi  output  1  master data out.
- miso  input  1  slave data in. The slave synchronises it; it is not synchronised here.

Behaviour:
- Reset: when rst=0 at a clk edge, the next cycle has sck=0, ss=1, mosi=0, busy=0, done=0, rx_data=0 and state IDLE. This applies mid-transfer too: the partial byte is discarded and no done is issued.
- States are IDLE, LOW, HIGH, TAIL, GAP. A counter of $clog2(CLK_DIV) bits counts 0..CLK_DIV-1. A bit index runs 7 down to 0.
- IDLE:
  - busy=0, sck=0.
  - start=1 at edge T loads the shift register with tx_data and latches ss_hold.
  - At T+1: busy=1, ss=0, mosi=tx_data[7], and the state moves to LOW with bit=7.
- LOW: sck=0 for CLK_DIV cycles, mosi stable. The first LOW of the byte also acts as the ss-to-sck setup time. Then move to HIGH.
- HIGH (entry):
  - sck=1.
  - On the same clk edge that raises sck, miso is shifted into the receive register at position bit.
  - sck stays 1 for CLK_DIV cycles.
  - On exit sck=0. If bit>0, bit decrements, mosi takes the next tx bit and the state returns to LOW. If bit=0, move to TAIL.
- TAIL: sck=0 and mosi holds the last bit for CLK_DIV cycles. This is the hold time before ss rises. Then, in one cycle:
  - done=1 and rx_data=receive register.
  - If ss_hold=0: ss=1, move to GAP, busy stays 1.
  - If ss_hold=1: ss stays 0, busy=0, move to IDLE.
- GAP: ss=1 for CLK_DIV cycles (minimum deselect time), then busy=0 and IDLE.
- Latency: done asserts exactly 1+17*CLK_DIV cycles after the accepting edge T. There are exactly 8 rising and 8 falling sck edges per byte.
- start while busy=1 is ignored; it is not queued. Changes to tx_data or ss_hold after acceptance have no effect.
- start in IDLE with ss already low (previous ss_hold=1) gives the same timing, but ss never rises.
- start asserted in the same cycle busy falls is not seen. It is accepted on the next edge if still held.
- done is never asserted for more than one cycle. rx_data holds its value between transfers.

Test Plan:
- Reset: hold rst=0 for 5 cycles mid-operation -> sck=0, ss=1, mosi=0, busy=0, done=0, rx_data=0x00.
- Loopback, CLK_DIV=4, miso tied to mosi, start with tx_data=0xA5 and ss_hold=0:
  - rx_data=0xA5.
  - done exactly 69 cycles after the accepting edge.
  - 8 sck rising edges, each sck phase 4 cycles wide.
  - ss high 4 cycles before busy=0.
- Against the `spi` slave (default CLK_DIV=25):
  - slave dout=0xBE, master sends 0x3C -> slave din=0x3C, master rx_data=0xBE.
  - Then dout=0xFF, master sends 0x00 -> din=0x00, rx_data=0xFF.
- ss_hold: two back-to-back bytes 0x12 (ss_hold=1) then 0x34 (ss_hold=0) -> ss stays 0 between bytes, two done pulses, ss rises with the second done.
- Ignore rules: pulse start and change tx_data to 0xFF mid-transfer of 0x81 -> only one done, mosi sequence is exactly 1,0,0,0,0,0,0,1.
- Reset after the 3rd sck rising edge -> next cycle ss=1, sck=0, busy=0, no done. A following 0x5A loopback then returns 0x5A.

Source files
------------

// File: rtl/spi_master.sv
// Single-byte SPI mode-0 master, MSB first, with a start/busy/done host handshake.
// Optional ss hold keeps the slave selected across consecutive bytes.
module spi_master #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       ss_hold,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
  input  logic       miso
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    TAIL,
    GAP
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          hold;

  assign cnt_last = (cnt == CW'(CLK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: state_next gets its default first so no path through the case
  // leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start)    state_next = LOW;
      LOW:  if (cnt_last) state_next = HIGH;
      HIGH: if (cnt_last) state_next = (bit_idx == 3'd0) ? TAIL : LOW;
      TAIL: if (cnt_last) state_next = hold ? IDLE : GAP;
      GAP:  if (cnt_last) state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  // Phase counter: restarts at every state change, parked at 0 in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == IDLE || cnt_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // NOTE: the shift registers carry no reset; they are always reloaded or
  // fully overwritten before their contents become visible.
  always_ff @(posedge clk) begin
    if (start && state == IDLE) begin
      tx_sr <= tx_data;
      hold  <= ss_hold;
    end
    if (state == LOW && cnt_last) rx_sr[bit_idx] <= miso;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      sck     <= 1'b0;
      ss      <= 1'b1;
      mosi    <= 1'b0;
      bit_idx <= 3'd7;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            ss      <= 1'b0;
            mosi    <= tx_data[7];
            bit_idx <= 3'd7;
          end
        end
        LOW: begin
          // miso is captured on this same edge (see shift-register block).
          if (cnt_last) sck <= 1'b1;
        end
        HIGH: begin
          if (cnt_last) begin
            sck <= 1'b0;
            if (bit_idx != 3'd0) begin
              bit_idx <= bit_idx - 3'd1;
              mosi    <= tx_sr[bit_idx - 3'd1];
            end
          end
        end
        TAIL: begin
          if (cnt_last) begin
            done    <= 1'b1;
            rx_data <= rx_sr;
            if (hold) busy <= 1'b0;
            else      ss   <= 1'b1;
          end
        end
        GAP: begin
          if (cnt_last) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
